id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the pipelined MIPS core, directly downstream of the register file. It captures the decoded instruction, both register read values and control bits at the end of ID and presents them to EX. It detects load-use hazards, stalls upstream and inserts bubbles. It also applies branch flushes and keeps a saturating bubble counter.

## Interface
Parameters:
- DW, 32, datapath width (register data, immediate)
- CW, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch taken in ID; current ID instruction is discarded
- idValid  in  1  ID holds a real instruction
- idReadData1, idReadData2  in  DW  register file read ports 1/2
- idImm  in  DW  sign-extended immediate
- idRs, idRt, idRd  in  5  instruction register fields
- idUsesRs, idUsesRt  in  1  instruction actually reads rs / rt
- idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst  in  1  decoded controls
- idAluOp  in  3  ALU operation
- stall  out  1  combinational; hold PC and IF/ID this cycle
- exValid  out  1  EX holds a real instruction
- exReadData1, exReadData2, exImm  out  DW  registered copies
- exRs, exRt, exWriteReg  out  5  exWriteReg = idRegDst ? idRd : idRt, resolved at capture
- exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc  out  1  registered controls
- exAluOp  out  3  registered ALU op
- bubbleCount  out  CW  bubbles inserted since reset, saturating

## Operation
- Hazard: `hazard = exValid & exMemRead & (exWriteReg != 0) & idValid & ((idUsesRs & idRs == exWriteReg) | (idUsesRt & idRt == exWriteReg))`.
- Stall: `stall = hazard & ~flush`.
- Per posedge, in priority order:
  - rst: every ex* output goes to 0, exValid to 0, bubbleCount to 0.
  - flush: insert a bubble. Hazard is ignored because the ID instruction dies.
  - stall: insert a bubble. ID inputs are not captured. Upstream holds them, and they are re-evaluated next cycle.
  - otherwise: capture all id* fields. exValid <= idValid.
- Bubble: exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg all 0. Data, register and other fields are also 0, so bubbles are deterministic.
- bubbleCount increments by 1 on each bubble caused by flush or stall. It holds at all-ones.
- A bubble caused by !idValid alone is a plain capture and is not counted.
- Writes to $0 never cause a hazard.
- No WB→ID forwarding is needed. The register file writes on negedge, so a same-cycle WB write is already in idReadData* at the next posedge.
- EX-stage forwarding is not in this block. exRs/exRt are exported for the forwarding unit.

## Timing
- Latency: 1 cycle, ID inputs → ex* outputs.
- stall is purely combinational from registered ex* state and the current id* inputs. It is valid before the posedge of the same cycle and has no dependence on itself.
- Load-use costs exactly one bubble. After the bubble, exMemRead = 0, so stall drops and the held instruction is captured next edge.
- Back-to-back loads feeding each other cost one bubble per dependent pair.
- Flush and hazard in the same cycle: one bubble, stall = 0, bubbleCount +1.
- rst asserted mid-stall: the next edge clears everything. stall is 0 from then, since exValid = 0.
- Reset values: all outputs 0, including stall (exValid = 0).

## Test plan
- Reset: drive random id* with rst = 1 for 2 cycles → all ex* = 0, exValid = 0, bubbleCount = 0, stall = 0.
- Pass-through: idValid = 1, idReadData1 = 0x1, idReadData2 = 0x2, idRd = 5, idRegDst = 1, idRegWrite = 1 → next cycle exReadData1 = 1, exReadData2 = 2, exWriteReg = 5, exRegWrite = 1, stall never 1.
- Load-use: lw into $3 captured (exMemRead = 1, exWriteReg = 3), then ID add with idRs = 3, idUsesRs = 1 → stall = 1 for one cycle, one bubble (exValid = 0), bubbleCount = 1, then add captured.
- No false hazard:
  - lw into $0 followed by a reader of $0 → stall = 0.
  - lw $3 followed by an instruction with idRt = 3 but idUsesRt = 0 → stall = 0.
- Flush priority: load-use condition plus flush = 1 in the same cycle → stall = 0, bubble inserted, bubbleCount +1, and the ID instruction is never captured.
- Saturation: CW = 4, force 20 flush cycles → bubbleCount stops at 15.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side decoded instruction in, EX-side registered copy,
// stall and bubble count out.
interface id_ex_stage_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
);
   logic          flush;
   logic          idValid;
   logic [DW-1:0] idReadData1;
   logic [DW-1:0] idReadData2;
   logic [DW-1:0] idImm;
   logic [4:0]    idRs;
   logic [4:0]    idRt;
   logic [4:0]    idRd;
   logic          idUsesRs;
   logic          idUsesRt;
   logic          idRegWrite;
   logic          idMemRead;
   logic          idMemWrite;
   logic          idMemToReg;
   logic          idAluSrc;
   logic          idRegDst;
   logic [2:0]    idAluOp;

   logic          stall;
   logic          exValid;
   logic [DW-1:0] exReadData1;
   logic [DW-1:0] exReadData2;
   logic [DW-1:0] exImm;
   logic [4:0]    exRs;
   logic [4:0]    exRt;
   logic [4:0]    exWriteReg;
   logic          exRegWrite;
   logic          exMemRead;
   logic          exMemWrite;
   logic          exMemToReg;
   logic          exAluSrc;
   logic [2:0]    exAluOp;
   logic [CW-1:0] bubbleCount;

   modport master (
      output flush, idValid, idReadData1, idReadData2, idImm, idRs, idRt, idRd,
             idUsesRs, idUsesRt, idRegWrite, idMemRead, idMemWrite, idMemToReg,
             idAluSrc, idRegDst, idAluOp,
      input  stall, exValid, exReadData1, exReadData2, exImm, exRs, exRt,
             exWriteReg, exRegWrite, exMemRead, exMemWrite, exMemToReg,
             exAluSrc, exAluOp, bubbleCount
   );

   modport slave (
      input  flush, idValid, idReadData1, idReadData2, idImm, idRs, idRt, idRd,
             idUsesRs, idUsesRt, idRegWrite, idMemRead, idMemWrite, idMemToReg,
             idAluSrc, idRegDst, idAluOp,
      output stall, exValid, exReadData1, exReadData2, exImm, exRs, exRt,
             exWriteReg, exRegWrite, exMemRead, exMemWrite, exMemToReg,
             exAluSrc, exAluOp, bubbleCount
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating count of inserted bubbles.
module id_ex_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.slave  bus
);
   localparam int unsigned RW = 5;
   localparam int unsigned OW = 3;

   logic          valid_q,    valid_d;
   logic [DW-1:0] rd1_q,      rd1_d;
   logic [DW-1:0] rd2_q,      rd2_d;
   logic [DW-1:0] imm_q,      imm_d;
   logic [RW-1:0] rs_q,       rs_d;
   logic [RW-1:0] rt_q,       rt_d;
   logic [RW-1:0] wreg_q,     wreg_d;
   logic          regwrite_q, regwrite_d;
   logic          memread_q,  memread_d;
   logic          memwrite_q, memwrite_d;
   logic          memtoreg_q, memtoreg_d;
   logic          alusrc_q,   alusrc_d;
   logic [OW-1:0] aluop_q,    aluop_d;
   logic [CW-1:0] bcnt_q,     bcnt_d;

   logic          hazard_c;
   logic          bubble_c;

   // Load in EX whose destination is read by the instruction now in ID.
   always_comb begin
      hazard_c = valid_q & memread_q & (wreg_q != RW'(0)) & bus.idValid &
                 ((bus.idUsesRs & (bus.idRs == wreg_q)) |
                  (bus.idUsesRt & (bus.idRt == wreg_q)));
   end

   // A flushed ID instruction dies, so it never needs to be held.
   assign bus.stall = hazard_c & ~bus.flush;

   always_comb begin
      bubble_c   = bus.flush | hazard_c;
      valid_d    = 1'b0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      wreg_d     = '0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      aluop_d    = '0;
      bcnt_d     = bcnt_q;
      if (!bubble_c) begin
         valid_d    = bus.idValid;
         rd1_d      = bus.idReadData1;
         rd2_d      = bus.idReadData2;
         imm_d      = bus.idImm;
         rs_d       = bus.idRs;
         rt_d       = bus.idRt;
         wreg_d     = bus.idRegDst ? bus.idRd : bus.idRt;
         regwrite_d = bus.idRegWrite;
         memread_d  = bus.idMemRead;
         memwrite_d = bus.idMemWrite;
         memtoreg_d = bus.idMemToReg;
         alusrc_d   = bus.idAluSrc;
         aluop_d    = bus.idAluOp;
      end else if (bcnt_q != {CW{1'b1}}) begin
         bcnt_d = bcnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         wreg_q     <= '0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         aluop_q    <= '0;
         bcnt_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         imm_q      <= imm_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         wreg_q     <= wreg_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
         alusrc_q   <= alusrc_d;
         aluop_q    <= aluop_d;
         bcnt_q     <= bcnt_d;
      end
   end

   assign bus.exValid     = valid_q;
   assign bus.exReadData1 = rd1_q;
   assign bus.exReadData2 = rd2_q;
   assign bus.exImm       = imm_q;
   assign bus.exRs        = rs_q;
   assign bus.exRt        = rt_q;
   assign bus.exWriteReg  = wreg_q;
   assign bus.exRegWrite  = regwrite_q;
   assign bus.exMemRead   = memread_q;
   assign bus.exMemWrite  = memwrite_q;
   assign bus.exMemToReg  = memtoreg_q;
   assign bus.exAluSrc    = alusrc_q;
   assign bus.exAluOp     = aluop_q;
   assign bus.bubbleCount = bcnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked against
// an instruction-level model of the stage; a CW=4 copy covers saturation.
module tb_id_ex_stage;
   typedef struct packed {
      logic        valid;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic        uses_rs, uses_rt, regwrite, memread, memwrite, memtoreg, alusrc, regdst;
      logic [2:0]  aluop;
   } id_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, wreg;
      logic        regwrite, memread, memwrite, memtoreg, alusrc;
      logic [2:0]  aluop;
   } ex_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_t  cur_id;
   logic cur_flush;

   id_ex_stage_if #(.DW(32), .CW(16)) bus16 ();
   id_ex_stage_if #(.DW(32), .CW(4))  bus4 ();

`define TB_CONNECT(b) \
   assign b.flush = cur_flush; assign b.idValid = cur_id.valid; \
   assign b.idReadData1 = cur_id.rd1; assign b.idReadData2 = cur_id.rd2; \
   assign b.idImm = cur_id.imm; assign b.idRs = cur_id.rs; assign b.idRt = cur_id.rt; \
   assign b.idRd = cur_id.rd; assign b.idUsesRs = cur_id.uses_rs; \
   assign b.idUsesRt = cur_id.uses_rt; assign b.idRegWrite = cur_id.regwrite; \
   assign b.idMemRead = cur_id.memread; assign b.idMemWrite = cur_id.memwrite; \
   assign b.idMemToReg = cur_id.memtoreg; assign b.idAluSrc = cur_id.alusrc; \
   assign b.idRegDst = cur_id.regdst; assign b.idAluOp = cur_id.aluop;

   `TB_CONNECT(bus16)
   `TB_CONNECT(bus4)

   id_ex_stage #(.DW(32), .CW(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus16.slave));
   id_ex_stage #(.DW(32), .CW(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   logic [119:0] obs16, obs4;
   assign obs16 = {bus16.exValid, bus16.exReadData1, bus16.exReadData2, bus16.exImm,
                   bus16.exRs, bus16.exRt, bus16.exWriteReg, bus16.exRegWrite,
                   bus16.exMemRead, bus16.exMemWrite, bus16.exMemToReg,
                   bus16.exAluSrc, bus16.exAluOp};
   assign obs4  = {bus4.exValid, bus4.exReadData1, bus4.exReadData2, bus4.exImm,
                   bus4.exRs, bus4.exRt, bus4.exWriteReg, bus4.exRegWrite,
                   bus4.exMemRead, bus4.exMemWrite, bus4.exMemToReg,
                   bus4.exAluSrc, bus4.exAluOp};

   // Model: the instruction sitting in EX and the total number of bubbles.
   ex_t         m_ex;
   int unsigned m_bubbles;
   logic        exp_stall;
   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic reads_load(input ex_t e, input id_t i);
      if (!(e.valid && e.memread) || e.wreg == 5'd0 || !i.valid) return 1'b0;
      return (i.uses_rs && i.rs == e.wreg) || (i.uses_rt && i.rt == e.wreg);
   endfunction

   function automatic ex_t capture(input id_t i);
      ex_t e;
      e.valid = i.valid;       e.rd1 = i.rd1;           e.rd2 = i.rd2;
      e.imm = i.imm;           e.rs = i.rs;             e.rt = i.rt;
      e.wreg = i.regdst ? i.rd : i.rt;
      e.regwrite = i.regwrite; e.memread = i.memread;   e.memwrite = i.memwrite;
      e.memtoreg = i.memtoreg; e.alusrc = i.alusrc;     e.aluop = i.aluop;
      return e;
   endfunction

   function automatic id_t rand_id();
      id_t i;
      i = {$urandom, $urandom, $urandom, $urandom};
      i.valid   = ($urandom_range(0, 7) != 0);
      i.rs      = 5'($urandom_range(0, 3));
      i.rt      = 5'($urandom_range(0, 3));
      i.rd      = 5'($urandom_range(0, 3));
      i.memread = ($urandom_range(0, 1) == 1);
      return i;
   endfunction

   task automatic step(input id_t i, input logic fl, input logic r);
      logic lu;
      cur_id = i; cur_flush = fl; rst = r;
      @(negedge clk);
      lu = reads_load(m_ex, i);
      exp_stall = lu && !fl;
      chk("stall16", 128'(bus16.stall), 128'(exp_stall));
      chk("stall4",  128'(bus4.stall),  128'(exp_stall));
      @(posedge clk); #1;
      if (r) begin
         m_ex = '0; m_bubbles = 0;
      end else if (fl || lu) begin
         m_ex = '0; m_bubbles++;
      end else begin
         m_ex = capture(i);
      end
      chk("ex16", 128'(obs16), 128'(m_ex));
      chk("ex4",  128'(obs4),  128'(m_ex));
      chk("bcnt16", 128'(bus16.bubbleCount), 128'((m_bubbles > 65535) ? 65535 : m_bubbles));
      chk("bcnt4",  128'(bus4.bubbleCount),  128'((m_bubbles > 15) ? 15 : m_bubbles));
   endtask

   function automatic id_t lw(input logic [4:0] dst);
      id_t i = '0;
      i.valid = 1; i.rs = 5'd1; i.uses_rs = 1; i.rt = dst; i.imm = 32'h10;
      i.regwrite = 1; i.memread = 1; i.memtoreg = 1; i.alusrc = 1;
      return i;
   endfunction

   initial begin
      id_t i;
      logic last_stall;
      cur_id = rand_id(); cur_flush = 1'b0; rst = 1'b1;
      m_ex = '0; m_bubbles = 0;
      @(posedge clk); #1;

      // Reset with random ID traffic
      step(rand_id(), 1'b0, 1'b1);
      step(rand_id(), 1'b0, 1'b1);
      chk("rst_valid", 128'(bus16.exValid), 128'(0));

      // Pass-through R-type
      i = '0; i.valid = 1; i.rd1 = 32'h1; i.rd2 = 32'h2; i.rd = 5'd5;
      i.regdst = 1; i.regwrite = 1;
      step(i, 1'b0, 1'b0);
      chk("pt_wreg", 128'(bus16.exWriteReg), 128'(5));
      chk("pt_rd1",  128'(bus16.exReadData1), 128'(1));

      // Load-use: one bubble, then the held add is captured
      step(lw(5'd3), 1'b0, 1'b0);
      i = '0; i.valid = 1; i.rs = 5'd3; i.uses_rs = 1; i.rt = 5'd4; i.uses_rt = 1;
      i.rd = 5'd6; i.regdst = 1; i.regwrite = 1; i.rd1 = 32'hAAAA; i.aluop = 3'd2;
      step(i, 1'b0, 1'b0);
      chk("lu_bubble", 128'(bus16.exValid), 128'(0));
      chk("lu_bcnt",   128'(bus16.bubbleCount), 128'(1));
      step(i, 1'b0, 1'b0);
      chk("lu_capt", 128'(bus16.exWriteReg), 128'(6));

      // Load into $0 never hazards
      step(lw(5'd0), 1'b0, 1'b0);
      i = '0; i.valid = 1; i.rs = 5'd0; i.uses_rs = 1; i.rt = 5'd0; i.uses_rt = 1;
      step(i, 1'b0, 1'b0);
      // rt matches but is not read
      step(lw(5'd3), 1'b0, 1'b0);
      i = '0; i.valid = 1; i.rs = 5'd7; i.uses_rs = 1; i.rt = 5'd3; i.uses_rt = 0;
      step(i, 1'b0, 1'b0);

      // Flush beats load-use
      step(lw(5'd3), 1'b0, 1'b0);
      i = '0; i.valid = 1; i.rs = 5'd3; i.uses_rs = 1; i.rd = 5'd9; i.regdst = 1;
      step(i, 1'b1, 1'b0);
      chk("fl_bcnt", 128'(bus16.bubbleCount), 128'(2));

      // Reset in the middle of a stall
      step(lw(5'd2), 1'b0, 1'b0);
      i = '0; i.valid = 1; i.rt = 5'd2; i.uses_rt = 1;
      step(i, 1'b0, 1'b1);
      step(i, 1'b0, 1'b0);

      // Saturation of the narrow counter
      for (int k = 0; k < 20; k++) step(rand_id(), 1'b1, 1'b0);
      chk("sat4",  128'(bus4.bubbleCount),  128'(15));
      chk("sat16", 128'(bus16.bubbleCount), 128'(20));

      // Random traffic; a stalled instruction is held upstream
      last_stall = 1'b0;
      i = rand_id();
      for (int k = 0; k < 400; k++) begin
         if (!last_stall) i = rand_id();
         step(i, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
         last_stall = exp_stall;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
